// File: rtl/rr_arb_pkg.sv
// Shared types and default sizing for the round-robin bus arbiter.
// Contents: FSM state enum, default requester count and hold limit.
// No logic; imported by rr_priority_pick and rr_bus_arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam int N_DEF        = 8;
    localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: picks the requester that follows last_id in the
// search order last_id-1, last_id-2, ... (mod N), ending at last_id itself.
// Ports: req[N], last_id[IDW] in; pick_id[IDW], pick_valid out. Purely combinational.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_id,
    output logic [IDW-1:0] pick_id,
    output logic           pick_valid
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IDW-1:0] enc_id;

    // Rotating right by last_id puts index last_id-1 in the MSB position, so an
    // MSB-first encoder walks exactly the required search order.
    assign req_dbl = {req, req} >> last_id;
    assign req_rot = req_dbl[N-1:0];

    always_comb begin
        enc_id = '0;
        // Ascending loop: the highest set bit is the last assignment and wins.
        for (int j = 0; j < N; j++) begin
            if (req_rot[j]) begin
                enc_id = IDW'(j);
            end
        end
    end

    // N is a power of two, so IDW-bit addition wraps modulo N for free.
    assign pick_id    = enc_id + last_id;
    assign pick_valid = |req;

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one datapath among N requesters; grant is registered.
// Ports: clk, rst (sync, active-high), req[N], done[N] in; grant[N] one-hot,
// grant_id[IDW], grant_valid, timeout (1-cycle revoke pulse) out.
module rr_bus_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           timeout
);

    localparam int HCW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_SAT  = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    state_t         state, state_n;
    logic [N-1:0]   grant_q, grant_n;
    logic [IDW-1:0] last_id, last_n;
    logic [HCW-1:0] hold_cnt, hold_n;
    logic           timeout_q, timeout_n;

    logic [IDW-1:0] pick_id;
    logic           pick_valid;
    logic           release_now;
    logic           hold_expired;

    rr_priority_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req        (req),
        .last_id    (last_id),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    // While OWNED the owner is always last_id, since last_id moves only on a grant.
    assign release_now  = done[last_id] | ~req[last_id];
    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_n   = state;
        grant_n   = grant_q;
        last_n    = last_id;
        hold_n    = hold_cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                grant_n = '0;
                if (pick_valid) begin
                    grant_n = {{(N-1){1'b0}}, 1'b1} << pick_id;
                    last_n  = pick_id;
                    hold_n  = '0;
                    state_n = OWNED;
                end
            end
            OWNED: begin
                // A normal release takes precedence over a timeout in the same cycle.
                if (release_now) begin
                    grant_n = '0;
                    state_n = IDLE;
                end else if (hold_expired) begin
                    grant_n   = '0;
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_q   <= '0;
            last_id   <= '0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            grant_q   <= grant_n;
            last_id   <= last_n;
            hold_cnt  <= hold_n;
            timeout_q <= timeout_n;
        end
    end

    // grant_id is the most recent winner; it holds after release, as the datapath expects.
    assign grant       = grant_q;
    assign grant_id    = last_id;
    assign grant_valid = |grant_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: directed vectors with literal expectations,
// a per-cycle reference model comparison, and a randomized tail with
// one-hot / hold-limit / starvation checks.
module tb_rr_bus_arbiter;

    localparam int N        = 8;
    localparam int IDW      = 3;
    localparam int MAX_HOLD = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   done = '0;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;
    logic           timeout;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    rr_bus_arbiter #(
        .N        (N),
        .IDW      (IDW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge; returns at the following falling edge with outputs settled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    // Owner is -1 when nobody holds the bus; m_held counts cycles the owner has had it.
    int           m_owner = -1;
    int           m_last  = 0;
    int           m_held  = 0;
    bit           m_to    = 1'b0;
    logic [N-1:0] req_s   = '0;

    always @(posedge clk) begin
        req_s = req;
        if (rst) begin
            m_owner = -1;
            m_last  = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last - k + N) % N;
                if (m_owner < 0 && req[idx]) begin
                    m_owner = idx;
                    m_last  = idx;
                    m_held  = 1;
                end
            end
        end else begin
            m_to = 1'b0;
            if (done[m_owner] || !req[m_owner]) begin
                m_owner = -1;
            end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end
    end

    // ---------------- per-cycle compare + invariants ----------------
    logic [N-1:0] prev_grant = '0;
    int           run_len    = 0;
    int           wait_cnt [N];

    always @(negedge clk) begin
        if (chk_on) begin
            logic [N-1:0] exp_g;
            exp_g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            check("model_grant", grant, exp_g);
            check("model_grant_valid", grant_valid, m_owner >= 0);
            check("model_grant_id", grant_id, m_last);
            check("model_timeout", timeout, m_to);
            check("onehot", $onehot0(grant), 1);

            if (grant != '0 && grant == prev_grant) run_len++;
            else run_len = (grant != '0) ? 1 : 0;
            if (grant != '0) check("max_hold", run_len <= MAX_HOLD, 1);

            if (rst) begin
                for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            end else if (grant != '0 && prev_grant == '0) begin
                for (int i = 0; i < N; i++) begin
                    if (grant[i]) begin
                        check("starvation", wait_cnt[i] <= N, 1);
                        wait_cnt[i] = 0;
                    end else if (req_s[i]) begin
                        wait_cnt[i]++;
                    end
                end
            end
            for (int i = 0; i < N; i++) if (!req_s[i]) wait_cnt[i] = 0;
        end
        prev_grant = grant;
    end

    // ---------------- stimulus ----------------
    initial begin
        int exp_seq [9];
        exp_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        // Reset state
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_on = 1'b1;
        check("rst_grant", grant, 8'h00);
        check("rst_grant_id", grant_id, 0);
        check("rst_valid", grant_valid, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;

        // First arbitration is MSB-first, then rotation hands over to 0
        req = 8'h81;
        tick();
        check("first_grant", grant, 8'h80);
        check("first_id", grant_id, 7);
        check("first_valid", grant_valid, 1);
        done = 8'h80;
        tick();
        check("release7_grant", grant, 8'h00);
        check("release7_id_held", grant_id, 7);
        done = 8'h00;
        tick();
        check("second_grant", grant, 8'h01);
        check("second_id", grant_id, 0);
        done = 8'h01;
        req  = 8'h00;
        tick();
        check("release0_grant", grant, 8'h00);
        done = 8'h00;

        // All requesting, immediate release: 7..0 then wrap to 7, with dead cycles
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick();
            check("rr_seq_id", grant_id, exp_seq[g]);
            check("rr_seq_grant", grant, 8'h01 << exp_seq[g]);
            done = 8'h01 << exp_seq[g];
            tick();
            check("rr_dead_cycle", grant, 8'h00);
            done = 8'h00;
        end

        // Timeout: owner 3 never releases, held exactly MAX_HOLD cycles
        req = 8'h08;
        tick();
        check("to_grant_first", grant, 8'h08);
        for (int c = 1; c < MAX_HOLD; c++) begin
            tick();
            check("to_held", grant, 8'h08);
            check("to_no_pulse", timeout, 0);
        end
        req = 8'h28;
        tick();
        check("to_revoked", grant, 8'h00);
        check("to_pulse", timeout, 1);
        tick();
        check("to_next_winner", grant, 8'h20);
        check("to_pulse_once", timeout, 0);
        done = 8'h20;
        tick();
        done = 8'h00;

        // Owner 4: non-owner done ignored, withdrawal releases without timeout
        req = 8'h10;
        tick();
        check("own4_grant", grant, 8'h10);
        done = 8'h04;
        tick();
        check("foreign_done_ignored", grant, 8'h10);
        done = 8'h00;
        req  = 8'h00;
        tick();
        check("withdraw_grant", grant, 8'h00);
        check("withdraw_no_timeout", timeout, 0);

        // Reset while OWNED drops the grant, no timeout, priority back to MSB-first
        req = 8'h80;
        tick();
        check("pre_rst_grant", grant, 8'h80);
        req = 8'h01;
        rst = 1'b1;
        tick();
        check("rst_owned_grant", grant, 8'h00);
        check("rst_owned_timeout", timeout, 0);
        rst = 1'b0;
        req = 8'h81;
        tick();
        check("post_rst_grant", grant, 8'h80);
        check("post_rst_id", grant_id, 7);
        done = 8'h80;
        req  = 8'h00;
        tick();
        done = 8'h00;

        // Randomized traffic; the model and invariants check every cycle
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [N-1:0] r, d;
            r = req;
            d = '0;
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    if ($urandom_range(7) == 0) begin
                        d[i] = 1'b1;
                        if ($urandom_range(1) == 0) r[i] = 1'b0;
                    end else if ($urandom_range(31) == 0) begin
                        r[i] = 1'b0;
                    end
                end else begin
                    if (!r[i] && $urandom_range(5) == 0) r[i] = 1'b1;
                    if ($urandom_range(15) == 0) d[i] = 1'b1;
                end
            end
            req  = r;
            done = d;
            tick();
        end
        req  = '0;
        done = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
